// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//
// Iterative signed multiplier/divider that responds to the control FSM's
// Start/DivMult handshake. One operation is accepted per Start pulse while
// idle, computed one bit per clock, and written into the HI/LO result
// registers on the same edge that raises Done.
//   mult : radix-2 Booth on a 2*WIDTH+1 bit accumulator {P, multiplier, q-1}
//   div  : restoring shift-subtract on operand magnitudes, sign fix-up last
//
// Timing, counted from the edge that samples Start (edge 0):
//   mult/div   : Done registers high on edge WIDTH+1
//   div by zero: Done and DivZero register high on edge 1
//
// Optional feature (compile-time macro MULTDIV_UNSIGNED_EN):
//   defined   -> adds input Unsgn, sampled with Start; 1 selects multu/divu
//   undefined -> no Unsgn port, every operation is signed
//
// Ports:
//   Clock    in   system clock, rising edge
//   Reset    in   synchronous, active-high reset (aborts any operation)
//   Start    in   one-cycle request, honoured only while Busy=0
//   DivMult  in   0 = mult, 1 = div (sampled with Start)
//   A        in   rs: multiplicand / dividend (sampled with Start)
//   B        in   rt: multiplier / divisor    (sampled with Start)
//   Unsgn    in   unsigned select (only with MULTDIV_UNSIGNED_EN)
//   Busy     out  operation in progress
//   Done     out  one-cycle completion pulse
//   DivZero  out  divide-by-zero flag, pulses together with Done
//   Hi       out  product[2W-1:W] or remainder
//   Lo       out  product[W-1:0]  or quotient
// ---------------------------------------------------------------------------
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic             DivMult,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
`ifdef MULTDIV_UNSIGNED_EN
   input  logic             Unsgn,
`endif
   output logic             Busy,
   output logic             Done,
   output logic             DivZero,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {
      IDLE,
      MRUN,
      DRUN,
      FIX,
      DZERO
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [CW-1:0]      cnt_q;
   logic               accept;
   logic               last_step;
   logic               done_d;
   logic               dz_d;

   // Operation context captured when Start is accepted
   logic               is_div_q;
   logic               unsgn_q;
   logic               rem_neg_q;
   logic               quo_neg_q;
   logic [WIDTH-1:0]   opnd_q;     // multiplicand (mult) or |divisor| (div)
   logic [2*WIDTH:0]   acc_q;      // mult: {P, Q, q-1}; div: {0, R, Q}
   logic [2*WIDTH:0]   acc_step;

   // Operand decode at the accept edge
   logic               unsgn_in;
   logic               a_neg_in;
   logic               b_neg_in;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;

   // Iteration datapath
   logic [WIDTH:0]     m_ext;
   logic [WIDTH:0]     booth_add;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH+1:0]   div_diff;

   // Result fix-up
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

`ifdef MULTDIV_UNSIGNED_EN
   assign unsgn_in = Unsgn;
`else
   assign unsgn_in = 1'b0;
`endif

   assign a_neg_in = A[WIDTH-1] & ~unsgn_in;
   assign b_neg_in = B[WIDTH-1] & ~unsgn_in;
   assign a_mag    = a_neg_in ? -A : A;
   assign b_mag    = b_neg_in ? -B : B;

   assign Busy      = (state_q != IDLE);
   assign last_step = (cnt_q == CW'(WIDTH-1));

   // ------------------------------------------------------------------
   // FSM next-state and control decode
   // ------------------------------------------------------------------
   // NOTE: every output of a combinational block gets a default before the
   // case statement; a path that leaves one unassigned infers a latch.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      done_d  = 1'b0;
      dz_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (Start) begin
               accept = 1'b1;
               if (!DivMult)
                  state_d = MRUN;
               else if (B == '0)
                  state_d = DZERO;
               else
                  state_d = DRUN;
            end
         end
         MRUN, DRUN: begin
            if (last_step)
               state_d = FIX;
         end
         FIX: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         DZERO: begin
            done_d  = 1'b1;
            dz_d    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept)
            cnt_q <= '0;
         else if (state_q == MRUN || state_q == DRUN)
            cnt_q <= cnt_q + CW'(1);
      end
   end

   // ------------------------------------------------------------------
   // One iteration step
   // ------------------------------------------------------------------
   always_comb begin
      // Signed mode keeps one extra sign bit so that subtracting the most
      // negative multiplicand cannot overflow; the shift takes the true sign
      // from bit WIDTH of the sum rather than from the old P.
      m_ext     = {opnd_q[WIDTH-1] & ~unsgn_q, opnd_q};
      booth_add = '0;
      if (unsgn_q) begin
         // Plain shift-add: the multiplier is zero-extended, no recoding.
         if (acc_q[1])
            booth_add = m_ext;
      end else begin
         case (acc_q[1:0])
            2'b01:   booth_add = m_ext;
            2'b10:   booth_add = -m_ext;
            default: booth_add = '0;
         endcase
      end
      mul_sum = {acc_q[2*WIDTH] & ~unsgn_q, acc_q[2*WIDTH:WIDTH+1]} + booth_add;

      // Restoring division. The trial difference is two bits wider than the
      // divisor so an unsigned divisor near 2^WIDTH still yields a valid
      // borrow bit.
      rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
      div_diff = {1'b0, rem_sh} - {2'b00, opnd_q};

      if (is_div_q) begin
         if (div_diff[WIDTH+1])
            acc_step = {1'b0, rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
         else
            acc_step = {1'b0, div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
         acc_step = {mul_sum, acc_q[WIDTH:1]};
      end
   end

   // NOTE: the working registers carry no reset; they are always loaded on
   // the accept edge before anything reads them, and Reset forces the FSM
   // back to IDLE so stale contents are never observed.
   always_ff @(posedge Clock) begin
      if (accept) begin
         is_div_q  <= DivMult;
         unsgn_q   <= unsgn_in;
         rem_neg_q <= a_neg_in;
         quo_neg_q <= a_neg_in ^ b_neg_in;
         if (DivMult) begin
            opnd_q <= b_mag;
            acc_q  <= {{(WIDTH+1){1'b0}}, a_mag};
         end else begin
            opnd_q <= A;
            acc_q  <= {{WIDTH{1'b0}}, B, 1'b0};
         end
      end else if (state_q == MRUN || state_q == DRUN) begin
         acc_q <= acc_step;
      end
   end

   // ------------------------------------------------------------------
   // Result registers: written only on the edge that raises Done
   // ------------------------------------------------------------------
   assign quo     = acc_q[WIDTH-1:0];
   assign rem     = acc_q[2*WIDTH-1:WIDTH];
   assign quo_fix = quo_neg_q ? -quo : quo;
   assign rem_fix = rem_neg_q ? -rem : rem;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         Hi      <= '0;
         Lo      <= '0;
         Done    <= 1'b0;
         DivZero <= 1'b0;
      end else begin
         Done    <= done_d;
         DivZero <= dz_d;
         if (state_q == FIX) begin
            if (is_div_q) begin
               Hi <= rem_fix;
               Lo <= quo_fix;
            end else begin
               {Hi, Lo} <= acc_q[2*WIDTH:1];
            end
         end
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
//
// Directed scoreboard bench for mult_div_unit. Stimulus tasks push the
// expected Hi/Lo/DivZero and the expected Done cycle into a queue; a monitor
// on the falling edge pops and compares every time Done is presented.
// Build with +define+MULTDIV_UNSIGNED_EN to also exercise multu/divu.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

   localparam int W = 32;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          Start;
   logic          DivMult;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic          Unsgn;
   logic          Busy;
   logic          Done;
   logic          DivZero;
   logic [W-1:0]  Hi;
   logic [W-1:0]  Lo;

   typedef struct {
      string        tag;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
      int unsigned  done_cyc;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   int unsigned cyc    = 0;
   int          done_seen = 0;

   mult_div_unit #(.WIDTH(W)) dut (
      .Clock   (Clock),
      .Reset   (Reset),
      .Start   (Start),
      .DivMult (DivMult),
      .A       (A),
      .B       (B),
`ifdef MULTDIV_UNSIGNED_EN
      .Unsgn   (Unsgn),
`endif
      .Busy    (Busy),
      .Done    (Done),
      .DivZero (DivZero),
      .Hi      (Hi),
      .Lo      (Lo)
   );

   always #5 Clock = ~Clock;

   always @(posedge Clock) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor
   always @(negedge Clock) begin
      if (Done === 1'b1) begin
         done_seen++;
         if (exp_q.size() == 0) begin
            check("done_without_request", 64'(exp_q.size()), 64'd1);
         end else begin
            mon_e = exp_q.pop_front();
            check({mon_e.tag, "_hi"},      64'(Hi),      64'(mon_e.hi));
            check({mon_e.tag, "_lo"},      64'(Lo),      64'(mon_e.lo));
            check({mon_e.tag, "_divzero"}, 64'(DivZero), 64'(mon_e.dz));
            check({mon_e.tag, "_latency"}, 64'(cyc),     64'(mon_e.done_cyc));
         end
      end else if (DivZero === 1'b1) begin
         check("divzero_without_done", 64'(DivZero), 64'd0);
      end
   end

   // Called at a falling edge; returns at the falling edge after the
   // sampling edge with Start dropped and the operands scrambled.
   task automatic issue(input string tag, input logic dm, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic us, input bit expect_done,
                        input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dz);
      exp_t e;
      Start   = 1'b1;
      DivMult = dm;
      A       = a;
      B       = b;
      Unsgn   = us;
      if (expect_done) begin
         e.tag      = tag;
         e.hi       = hi;
         e.lo       = lo;
         e.dz       = dz;
         e.done_cyc = cyc + 1 + ((dm && b == '0) ? 1 : W + 1);
         exp_q.push_back(e);
      end
      @(negedge Clock);
      Start   = 1'b0;
      DivMult = 1'($urandom);
      A       = $urandom;
      B       = $urandom;
      Unsgn   = 1'($urandom);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || Busy !== 1'b0) && n < 200) begin
         @(negedge Clock);
         n++;
      end
      @(negedge Clock);
      check({tag, "_drain_in_time"}, 64'(n < 200), 64'd1);
   endtask

   initial begin
      int bad;
      int n;
      int done_before;
      Reset   = 1'b1;
      Start   = 1'b0;
      DivMult = 1'b0;
      A       = '0;
      B       = '0;
      Unsgn   = 1'b0;
      repeat (3) @(negedge Clock);
      Reset = 1'b0;

      // Reset state
      check("reset_busy",    64'(Busy),    64'd0);
      check("reset_done",    64'(Done),    64'd0);
      check("reset_divzero", 64'(DivZero), 64'd0);
      check("reset_hi",      64'(Hi),      64'd0);
      check("reset_lo",      64'(Lo),      64'd0);

      // 7 * -3 with Busy window and held result registers
      issue("mult_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b1,
            32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      bad = 0;
      for (int i = 0; i <= W; i++) begin
         if (Busy !== 1'b1 || Done !== 1'b0 || Hi !== '0 || Lo !== '0) bad++;
         @(negedge Clock);
      end
      check("mult_7_m3_busy_window", 64'(bad), 64'd0);
      check("mult_7_m3_busy_after",  64'(Busy), 64'd0);
      drain("mult_7_m3");

      issue("mult_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1,
            32'h4000_0000, 32'h0000_0000, 1'b0);
      drain("mult_min_min");

      issue("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1,
            32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      drain("div_m7_2");

      issue("div_5_m3", 1'b1, 32'd5, 32'hFFFF_FFFD, 1'b0, 1'b1,
            32'd2, 32'hFFFF_FFFF, 1'b0);
      drain("div_5_m3");

      // Preload Hi=0x11, Lo=0x22, then divide by zero
      issue("div_preload", 1'b1, 32'h0000_0451, 32'h0000_0020, 1'b0, 1'b1,
            32'h11, 32'h22, 1'b0);
      drain("div_preload");
      issue("div_by_zero", 1'b1, 32'd5, 32'd0, 1'b0, 1'b1,
            32'h11, 32'h22, 1'b1);
      check("div_by_zero_busy", 64'(Busy), 64'd1);
      drain("div_by_zero");

      // Overflow quotient, plus a Start at edge 10 that must be ignored
      issue("div_overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1,
            32'h0, 32'h8000_0000, 1'b0);
      repeat (9) @(negedge Clock);
      done_before = done_seen;
      Start   = 1'b1;
      DivMult = 1'b1;
      A       = 32'd9;
      B       = 32'd3;
      @(negedge Clock);
      Start = 1'b0;
      drain("div_overflow");
      check("div_overflow_single_done", 64'(done_seen - done_before), 64'd1);

      // Back-to-back: Start in the cycle Done is high
      issue("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0, 1'b1,
            32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);
      n = 0;
      while (Done !== 1'b1 && n < 100) begin
         @(negedge Clock);
         n++;
      end
      check("b2b_done_in_time", 64'(n < 100), 64'd1);
      issue("mult_b2b", 1'b0, 32'h1234_5678, 32'h0000_0010, 1'b0, 1'b1,
            32'h0000_0001, 32'h2345_6780, 1'b0);
      check("b2b_busy", 64'(Busy), 64'd1);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (Hi !== 32'hFFFF_FFFE || Lo !== 32'hFFFF_FFF2) bad++;
         @(negedge Clock);
      end
      check("b2b_hold_old_result", 64'(bad), 64'd0);
      drain("mult_b2b");

      // Reset mid-operation aborts without Done
      issue("mult_abort", 1'b0, 32'd3, 32'd4, 1'b0, 1'b0, '0, '0, 1'b0);
      repeat (9) @(negedge Clock);
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      check("abort_busy", 64'(Busy), 64'd0);
      check("abort_hi",   64'(Hi),   64'd0);
      check("abort_lo",   64'(Lo),   64'd0);
      done_before = done_seen;
      repeat (40) @(negedge Clock);
      check("abort_no_done", 64'(done_seen - done_before), 64'd0);

`ifdef MULTDIV_UNSIGNED_EN
      issue("multu_ffff_2", 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b1,
            32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
      drain("multu_ffff_2");
      issue("mult_m1_2", 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1,
            32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
      drain("mult_m1_2");
      issue("divu_ffff_2", 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b1,
            32'h0000_0001, 32'h7FFF_FFFF, 1'b0);
      drain("divu_ffff_2");
      issue("div_m1_2", 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1,
            32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
      drain("div_m1_2");
      issue("divu_big_divisor", 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 1'b1,
            32'hFFFF_FFFE, 32'h0000_0000, 1'b0);
      drain("divu_big_divisor");
`endif

      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
